// File: rtl/ir_transmit_if.sv
// ----------------------------------------------------------------------------
// ir_transmit_if
// Bundles the request and line signals of the IR transmitter.
//   send      : request to transmit (driven by master)
//   code[2:0] : button code, MSB first (driven by master)
//   irda_txd  : IR line, idle high (driven by slave)
//   busy      : frame in progress (driven by slave)
//   done      : one-cycle pulse at frame completion (driven by slave)
//   err       : one-cycle pulse on a request with an invalid code (driven by slave)
// ----------------------------------------------------------------------------
interface ir_transmit_if;
    logic       send;
    logic [2:0] code;
    logic       irda_txd;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output send,
        output code,
        input  irda_txd,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  send,
        input  code,
        output irda_txd,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/ir_transmit.sv
// ----------------------------------------------------------------------------
// ir_transmit
// Sends a 3-bit button code as a fixed 320-cycle IR frame:
//   start low pulse, high gap, three data windows (code[2], code[1], code[0]),
//   trailing high guard. The line idles high.
// Ports:
//   clk_pll : system clock, rising edge
//   reset   : synchronous, active-high reset
//   ir      : ir_transmit_if.slave (send/code in, irda_txd/busy/done/err out)
// All outputs are registered.
// ----------------------------------------------------------------------------
module ir_transmit #(
    parameter logic [8:0] T_GAP  = 9'h040,
    parameter logic [8:0] T_B2   = 9'h0A0,
    parameter logic [8:0] T_B1   = 9'h0D8,
    parameter logic [8:0] T_B0   = 9'h0F4,
    parameter logic [8:0] T_STOP = 9'h120,
    parameter logic [8:0] T_END  = 9'h13F
) (
    input  logic         clk_pll,
    input  logic         reset,
    ir_transmit_if.slave ir
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_BIT2  = 3'd3;
    localparam logic [2:0] S_BIT1  = 3'd4;
    localparam logic [2:0] S_BIT0  = 3'd5;
    localparam logic [2:0] S_STOP  = 3'd6;

    logic [2:0] state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [2:0] code_q, code_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [8:0] cnt_inc_s;
    logic [2:0] win_s;

    // Only five of the eight code values map to buttons.
    function automatic logic code_valid(input logic [2:0] c);
        logic v;
        case (c)
            3'b100, 3'b011, 3'b110, 3'b010, 3'b001: v = 1'b1;
            default:                                v = 1'b0;
        endcase
        return v;
    endfunction

    // Frame window that owns a given counter value.
    function automatic logic [2:0] window_of(input logic [8:0] c);
        logic [2:0] w;
        if (c < T_GAP) begin
            w = S_START;
        end else if (c < T_B2) begin
            w = S_GAP;
        end else if (c < T_B1) begin
            w = S_BIT2;
        end else if (c < T_B0) begin
            w = S_BIT1;
        end else if (c < T_STOP) begin
            w = S_BIT0;
        end else begin
            w = S_STOP;
        end
        return w;
    endfunction

    // Line level driven while in a given window.
    function automatic logic line_level(input logic [2:0] st, input logic [2:0] c);
        logic l;
        case (st)
            S_START: l = 1'b0;
            S_BIT2:  l = c[2];
            S_BIT1:  l = c[1];
            S_BIT0:  l = c[0];
            default: l = 1'b1;
        endcase
        return l;
    endfunction

    // Window lookup uses the incremented count so the state and the line
    // change on the same edge the counter enters a new window.
    assign cnt_inc_s = cnt_q + 9'd1;
    assign win_s     = window_of(cnt_inc_s);

    // Next-state logic: request acceptance, frame sequencing, completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ir.send) begin
                    if (code_valid(ir.code)) begin
                        code_d  = ir.code;
                        cnt_d   = 9'd0;
                        state_d = S_START;
                        txd_d   = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START, S_GAP, S_BIT2, S_BIT1, S_BIT0, S_STOP: begin
                if (cnt_q == T_END) begin
                    state_d = S_IDLE;
                    cnt_d   = 9'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_inc_s;
                    state_d = win_s;
                    txd_d   = line_level(win_s, code_q);
                    busy_d  = 1'b1;
                end
            end
            default: begin
                // Unreachable encodings fall back to a quiet idle line.
                state_d = S_IDLE;
                cnt_d   = 9'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_pll) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 9'd0;
            code_q  <= 3'b000;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ir.irda_txd = txd_q;
    assign ir.busy     = busy_q;
    assign ir.done     = done_q;
    assign ir.err      = err_q;

endmodule

// File: tb/tb_ir_transmit.sv
module tb_ir_transmit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ir_transmit_if bus ();

    ir_transmit dut (
        .clk_pll (clk),
        .reset   (reset),
        .ir      (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    // A frame is described only by its offset from the first low cycle.
    logic       m_active = 1'b0;
    int         m_off    = 0;
    logic [2:0] m_code   = 3'b000;
    logic       m_done   = 1'b0;
    logic       m_err    = 1'b0;

    function automatic logic is_valid(input logic [2:0] c);
        return (c inside {3'b100, 3'b011, 3'b110, 3'b010, 3'b001});
    endfunction

    // Offsets: low 0..63, gap 64..159, bit2 160..215, bit1 216..243,
    // bit0 244..287, guard 288..319.
    function automatic logic exp_line(input int t, input logic [2:0] c);
        if (t < 64)       return 1'b0;
        else if (t < 160) return 1'b1;
        else if (t < 216) return c[2];
        else if (t < 244) return c[1];
        else if (t < 288) return c[0];
        else              return 1'b1;
    endfunction

    always @(posedge clk) begin
        m_done <= 1'b0;
        m_err  <= 1'b0;
        if (reset === 1'b1) begin
            m_active <= 1'b0;
            m_off    <= 0;
        end else if (m_active) begin
            if (m_off == 319) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_off <= m_off + 1;
            end
        end else if (bus.send === 1'b1) begin
            if (is_valid(bus.code)) begin
                m_active <= 1'b1;
                m_off    <= 0;
                m_code   <= bus.code;
            end else begin
                m_err <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("txd",  {31'd0, bus.irda_txd}, {31'd0, (m_active ? exp_line(m_off, m_code) : 1'b1)});
                check("busy", {31'd0, bus.busy},     {31'd0, m_active});
                check("done", {31'd0, bus.done},     {31'd0, m_done});
                check("err",  {31'd0, bus.err},      {31'd0, m_err});
            end
        end
    end

    // ---------------- frame recorder / reference receiver ----------------
    logic rec [0:511];
    int   rlen     = 0;
    int   n_starts = 0;
    int   n_dones  = 0;
    logic busy_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1 && busy_prev !== 1'b1) begin
                rlen = 0;
                n_starts++;
            end
            if (bus.busy === 1'b1 && rlen < 512) begin
                rec[rlen] = bus.irda_txd;
                rlen++;
            end
            if (bus.done === 1'b1) n_dones++;
            busy_prev = bus.busy;
        end
    end

    // Receiver samples at 0xC1, 0xEA, 0xFE from the first low cycle.
    task automatic rx_check(input string name, input logic [2:0] exp_code);
        check({name, "_ready"}, {31'd0, (rlen == 320 && rec[0] === 1'b0)}, 32'd1);
        check({name, "_code"},  {29'd0, rec[193], rec[234], rec[254]}, {29'd0, exp_code});
    endtask

    task automatic do_send(input logic [2:0] c);
        @(posedge clk); #2;
        bus.send = 1'b1;
        bus.code = c;
        @(posedge clk); #2;
        bus.send = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_idle_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    logic [2:0] codes [0:4];
    logic [2:0] bad   [0:2];
    int   d0, s0, zeros;
    bit   got;

    initial begin
        codes[0] = 3'b100; codes[1] = 3'b011; codes[2] = 3'b110;
        codes[3] = 3'b010; codes[4] = 3'b001;
        bad[0] = 3'b101; bad[1] = 3'b000; bad[2] = 3'b111;

        reset    = 1'b1;
        bus.send = 1'b0;
        bus.code = 3'b000;
        repeat (3) @(posedge clk);
        #2 chk_en = 1'b1;
        @(negedge clk);
        check("rst_txd",  {31'd0, bus.irda_txd}, 32'd1);
        check("rst_busy", {31'd0, bus.busy},     32'd0);
        check("rst_done", {31'd0, bus.done},     32'd0);
        check("rst_err",  {31'd0, bus.err},      32'd0);
        @(posedge clk); #2 reset = 1'b0;

        // Single 3'b100 frame with hand-computed waveform points.
        d0 = n_dones;
        do_send(3'b100);
        wait_idle("f100");
        zeros = 0;
        for (int i = 0; i < 320; i++) if (rec[i] === 1'b0) zeros++;
        check("f100_len",   rlen, 32'd320);
        check("f100_zeros", zeros, 32'd136);
        check("f100_63",  {31'd0, rec[63]},  32'd0);
        check("f100_64",  {31'd0, rec[64]},  32'd1);
        check("f100_215", {31'd0, rec[215]}, 32'd1);
        check("f100_216", {31'd0, rec[216]}, 32'd0);
        check("f100_287", {31'd0, rec[287]}, 32'd0);
        check("f100_288", {31'd0, rec[288]}, 32'd1);
        check("f100_319", {31'd0, rec[319]}, 32'd1);
        check("f100_done_now", {31'd0, bus.done}, 32'd1);
        repeat (4) @(negedge clk);
        check("f100_ndone", n_dones - d0, 32'd1);

        // Loopback decode of every valid code.
        for (int k = 0; k < 5; k++) begin
            do_send(codes[k]);
            wait_idle("loop");
            rx_check("loop", codes[k]);
        end

        // Invalid codes: one-cycle err, line stays idle.
        for (int k = 0; k < 3; k++) begin
            s0 = n_starts;
            d0 = n_dones;
            do_send(bad[k]);
            @(negedge clk);
            check("bad_err1", {31'd0, bus.err},      32'd1);
            check("bad_busy", {31'd0, bus.busy},     32'd0);
            check("bad_txd",  {31'd0, bus.irda_txd}, 32'd1);
            @(negedge clk);
            check("bad_err0", {31'd0, bus.err}, 32'd0);
            check("bad_nostart", n_starts - s0, 32'd0);
            check("bad_nodone",  n_dones - d0,  32'd0);
        end

        // Send with a new code mid-frame is ignored.
        s0 = n_starts;
        do_send(3'b011);
        repeat (9'h050) @(posedge clk);
        #2;
        bus.send = 1'b1;
        bus.code = 3'b001;
        @(posedge clk); #2 bus.send = 1'b0;
        wait_idle("ign");
        rx_check("ign", 3'b011);
        repeat (20) @(negedge clk);
        check("ign_starts", n_starts - s0, 32'd1);

        // Send held across frame end: back-to-back with one idle cycle.
        s0 = n_starts;
        @(posedge clk); #2;
        bus.send = 1'b1;
        bus.code = 3'b010;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("b2b_done_seen", {31'd0, got}, 32'd1);
        check("b2b_gap_busy", {31'd0, bus.busy},     32'd0);
        check("b2b_gap_txd",  {31'd0, bus.irda_txd}, 32'd1);
        @(posedge clk); #2 bus.send = 1'b0;
        @(negedge clk);
        check("b2b_2nd_busy", {31'd0, bus.busy},     32'd1);
        check("b2b_2nd_txd",  {31'd0, bus.irda_txd}, 32'd0);
        wait_idle("b2b");
        rx_check("b2b", 3'b010);
        check("b2b_starts", n_starts - s0, 32'd2);

        // Reset mid-frame at counter 0x0E0.
        d0 = n_dones;
        do_send(3'b110);
        repeat (9'h0E0) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy},     32'd0);
        check("abort_txd",  {31'd0, bus.irda_txd}, 32'd1);
        check("abort_len",  rlen, 32'd225);
        repeat (5) @(negedge clk);
        check("abort_nodone", n_dones - d0, 32'd0);
        do_send(3'b110);
        wait_idle("after_abort");
        rx_check("after_abort", 3'b110);

        // Reset wins over a simultaneous send.
        @(posedge clk); #2;
        reset    = 1'b1;
        bus.send = 1'b1;
        bus.code = 3'b100;
        @(posedge clk); #2;
        reset    = 1'b0;
        bus.send = 1'b0;
        @(negedge clk);
        check("rst_prio_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
